// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Byte-enable patterns and the alignment rule live here.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Shape of the enable mask decides which low address bits must be zero.
  function automatic logic be_legal(
    input logic [1:0] a,
    input logic [3:0] be
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (be == BE_WORD):
        ok = (a == 2'b00);
      (be == BE_HALF),
      (be == (BE_HALF << 2)):
        ok = !a[0];
      (be == BE_BYTE),
      (be == (BE_BYTE << 1)),
      (be == (BE_BYTE << 2)),
      (be == (BE_BYTE << 3)):
        ok = 1'b1;
      default:
        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_arb_prio.sv
// Grant selection between CPU and DMA ports.
// Keeps the DMA port from being starved by a busy CPU.
module dmem_arb_prio
  import dmem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  input  logic       idle,
  output logic [1:0] req_ready,
  output logic       gnt
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic          accept;

  always_comb begin
    req_ready = 2'b00;
    gnt = (starve_cnt == LIM && req_valid[1])
        || !req_valid[0];
    if (idle) begin
      req_ready[gnt] = req_valid[gnt];
    end
  end

  assign accept = idle && (|req_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (accept) begin
      if (gnt) begin
        starve_cnt <= '0;
      end else if (req_valid[1]
                   && starve_cnt != LIM) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory.
// One request in flight; illegal accesses answer without a memory cycle.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] ADDR_LIMIT =
    32'h0002_0000,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*DATA_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  input  logic [7:0]              req_be,
  output logic [1:0]              rsp_valid,
  output logic                    rsp_err,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [DATA_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [3:0]              mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int W = DATA_WIDTH;

  state_t state, nstate;

  logic [1:0] ready;
  logic       gnt;
  logic       idle;
  logic       accept;
  logic       illegal;

  logic         sel_we;
  logic [W-1:0] sel_addr;
  logic [W-1:0] sel_wdata;
  logic [3:0]   sel_be;

  logic         own_q;
  logic         we_q;
  logic         err_q;
  logic [W-1:0] addr_q;
  logic [W-1:0] wdata_q;
  logic [3:0]   be_q;

  assign idle = (state == IDLE);

  dmem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .idle      (idle),
    .req_ready (ready),
    .gnt       (gnt)
  );

  assign req_ready = ready;
  assign accept = |ready;

  always_comb begin
    sel_we = req_we[gnt];
    sel_addr = gnt ? req_addr[2*W-1:W]
                   : req_addr[W-1:0];
    sel_wdata = gnt ? req_wdata[2*W-1:W]
                    : req_wdata[W-1:0];
    sel_be = gnt ? req_be[7:4] : req_be[3:0];
    illegal = (sel_addr >= ADDR_LIMIT)
           || !be_legal(sel_addr[1:0], sel_be);
  end

  // Payload is captured only on accept; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      own_q <= 1'b0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
    end else begin
      state <= nstate;
      if (accept) begin
        own_q <= gnt;
        we_q <= sel_we;
        err_q <= illegal;
        addr_q <= sel_addr;
        wdata_q <= sel_wdata;
        be_q <= sel_be;
      end
    end
  end

  always_comb begin
    nstate = state;
    mem_en = 1'b0;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    mem_be = 4'b0000;
    rsp_valid = 2'b00;
    rsp_err = 1'b0;
    rsp_rdata = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          nstate = illegal ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        mem_en = 1'b1;
        mem_we = we_q;
        mem_addr = {addr_q[W-1:2], 2'b00};
        mem_wdata = wdata_q;
        mem_be = be_q;
        nstate = RESP;
      end
      RESP: begin
        rsp_valid[own_q] = 1'b1;
        rsp_err = err_q;
        if (!err_q && !we_q) begin
          rsp_rdata = mem_rdata;
        end
        nstate = IDLE;
      end
      default: begin
        nstate = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter.
// Vector table plus hand sequences; responses checked from a queue.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_be;
  logic [1:0]  rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata)
  );

  logic [7:0]  mem [0:131071];
  logic [31:0] rd_q;

  assign mem_rdata = rd_q;

  // Memory model: synchronous read, data visible the cycle after mem_en.
  initial begin
    for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
    mem[32'h100] = 8'hDE;
    mem[32'h101] = 8'hAD;
    mem[32'h102] = 8'hBE;
    mem[32'h103] = 8'hEF;
    rd_q = 32'h0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        int a;
        a = int'(mem_addr[16:0]);
        for (int k = 0; k < 4; k++) begin
          if (mem_we && mem_be[k])
            mem[a+k] <= mem_wdata[8*k +: 8];
        end
        rd_q <= {mem[a+3], mem[a+2],
                 mem[a+1], mem[a]};
      end
    end
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timed out at cycle %0d",
             nm, cyc);
  endtask

  typedef struct {
    int          port;
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin
    if (rst_n && (|rsp_valid)) begin
      exp_t e;
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
      end else begin
        e = sb.pop_front();
        chk("rsp_port", 32'(rsp_valid),
            (e.port == 1) ? 32'd2 : 32'd1);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[16];

  task automatic wait_ready(
    input int p,
    output logic ok
  );
    int n;
    n = 0;
    while (!req_ready[p] && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready[p];
  endtask

  task automatic run_req(input vec_t v);
    logic ok;
    int p;
    p = v.port;
    @(negedge clk);
    req_valid[p] = 1'b1;
    req_we[p] = v.we;
    req_addr[p*32 +: 32] = v.addr;
    req_wdata[p*32 +: 32] = v.wdata;
    req_be[p*4 +: 4] = v.be;
    #1;
    wait_ready(p, ok);
    if (!ok) begin
      timeout("accept");
      req_valid = 2'b00;
      return;
    end
    chk("ready_other", 32'(req_ready[1-p]), 32'h0);
    sb.push_back('{p, cyc + (v.err ? 1 : 2),
                   v.err, v.rdata});
    @(posedge clk);
    #1;
    // Scramble the payload to prove the latched copy is used.
    req_valid[p] = 1'b0;
    req_we[p] = ~v.we;
    req_addr[p*32 +: 32] = ~v.addr;
    req_wdata[p*32 +: 32] = ~v.wdata;
    req_be[p*4 +: 4] = ~v.be;
    @(negedge clk);
    chk("mem_en", 32'(mem_en), 32'(!v.err));
    chk("ready_busy", 32'(req_ready), 32'h0);
    if (!v.err) begin
      chk("mem_addr", mem_addr,
          {v.addr[31:2], 2'b00});
      chk("mem_we", 32'(mem_we), 32'(v.we));
      chk("mem_be", 32'(mem_be), 32'(v.be));
      if (v.we) chk("mem_wdata", mem_wdata, v.wdata);
      @(negedge clk);
    end
  endtask

  int exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int order[10];

  initial begin
    logic ok;
    int g;
    int n;
    vec_t rv;

    vecs[0]  = '{0, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 32'hEFBEADDE};
    vecs[1]  = '{1, 1'b1, 32'h203, 32'h5A000000, 4'h8, 1'b0, 32'h0};
    vecs[2]  = '{0, 1'b0, 32'h200, 32'h0, 4'hF, 1'b0, 32'h5A000000};
    vecs[3]  = '{0, 1'b0, 32'h102, 32'h0, 4'hF, 1'b1, 32'h0};
    vecs[4]  = '{1, 1'b0, 32'h20000, 32'h0, 4'hF, 1'b1, 32'h0};
    vecs[5]  = '{0, 1'b1, 32'h104, 32'h00001234, 4'h3, 1'b0, 32'h0};
    vecs[6]  = '{0, 1'b1, 32'h106, 32'hABCD0000, 4'hC, 1'b0, 32'h0};
    vecs[7]  = '{1, 1'b0, 32'h104, 32'h0, 4'hF, 1'b0, 32'hABCD1234};
    vecs[8]  = '{0, 1'b0, 32'h101, 32'h0, 4'h3, 1'b1, 32'h0};
    vecs[9]  = '{0, 1'b0, 32'h100, 32'h0, 4'h5, 1'b1, 32'h0};
    vecs[10] = '{0, 1'b0, 32'h1FFFC, 32'h0, 4'hF, 1'b0, 32'h0};
    vecs[11] = '{1, 1'b1, 32'h101, 32'h00007700, 4'h2, 1'b0, 32'h0};
    vecs[12] = '{0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 32'h0};
    vecs[13] = '{0, 1'b1, 32'h102, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0};
    vecs[14] = '{0, 1'b1, 32'h20000, 32'h12345678, 4'hF, 1'b1, 32'h0};
    vecs[15] = '{0, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 32'hEFBE77DE};

    rst_n = 1'b0;
    req_valid = 2'b00;
    req_we = 2'b00;
    req_addr = '0;
    req_wdata = '0;
    req_be = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_req(vecs[i]);

    // Reset in the ISSUE cycle of a write must drop it entirely.
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0] = 1'b1;
    req_addr[31:0] = 32'h300;
    req_wdata[31:0] = 32'h11223344;
    req_be[3:0] = 4'hF;
    #1;
    wait_ready(0, ok);
    if (!ok) begin
      timeout("rst_accept");
    end else begin
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      @(negedge clk);
      chk("mid_mem_en", 32'(mem_en), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("mid_mem_en_rst", 32'(mem_en), 32'h0);
      chk("mid_mem_we_rst", 32'(mem_we), 32'h0);
      chk("mid_mem_addr_rst", mem_addr, 32'h0);
      chk("mid_mem_wdata_rst", mem_wdata, 32'h0);
      chk("mid_mem_be_rst", 32'(mem_be), 32'h0);
      chk("mid_rsp_rst", 32'(rsp_valid), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("mid_mem_byte", 32'(mem[32'h300]), 32'h0);
      rv = '{0, 1'b0, 32'h300, 32'h0, 4'hF, 1'b0, 32'h0};
      run_req(rv);
    end

    // Both ports requesting back to back.
    @(negedge clk);
    req_we = 2'b00;
    req_addr = {32'h104, 32'h100};
    req_be = 8'hFF;
    req_valid = 2'b11;
    #1;
    g = 0;
    n = 0;
    while (g < 10 && n < 100) begin
      if (|req_ready) begin
        order[g] = req_ready[1] ? 1 : 0;
        sb.push_back('{order[g], cyc + 2, 1'b0,
                       order[g] ? 32'hABCD1234
                                : 32'hEFBE77DE});
        g++;
      end
      @(negedge clk);
      n++;
    end
    req_valid = 2'b00;
    if (g < 10) timeout("starve_grants");
    for (int k = 0; k < g; k++)
      chk($sformatf("grant_%0d", k),
          order[k], exp_order[k]);
    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, byte-addressed data memory between two requesters.
- Port 0 is the CPU load/store path (MEM stage). Port 1 is the DMA/program-loader path.
- Serialises accesses with a small FSM, checks alignment and range, and drives the memory strobes.
- Returns one response per accepted request, with anti-starvation for port 1.

Parameters:
- DATA_WIDTH, 32, data and address width.
- ADDR_LIMIT, 32'h0002_0000, first illegal byte address (memory is 2^17 bytes).
- STARVE_LIMIT, 4, consecutive port-0 grants while port 1 waits before port 1 is forced.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-port request valid; bit i = port i.
- req_ready  out  2  per-port accept; at most one bit high.
- req_we  in  2  per-port write enable.
- req_addr  in  2x32  per-port byte address.
- req_wdata  in  2x32  per-port write data, little-endian lanes.
- req_be  in  2x4  per-port byte enables.
- rsp_valid  out  2  one-cycle response pulse to the owning port.
- rsp_err  out  1  qualifies rsp_valid; access was rejected.
- rsp_rdata  out  32  read data; valid with rsp_valid for reads.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_addr  out  32  word-aligned memory address.
- mem_wdata  out  32  memory write data.
- mem_be  out  4  memory byte enables.
- mem_rdata  in  32  memory read data, valid the cycle after mem_en.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, starve_cnt=0.
  - req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
  - Reset mid-transaction drops the transaction: no rsp_valid and no memory write afterwards.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready is combinational. Grant goes to port 1 if (starve_cnt==STARVE_LIMIT && req_valid[1]) or !req_valid[0]; otherwise to port 0.
  - req_ready[g]=req_valid[g]; the other bit is 0.
  - On accept, latch owner, we, addr, wdata and be.
  - If the access is legal, go to ISSUE. If illegal, go to RESP with the error flag set.
- Legal access requires all of:
  - addr < ADDR_LIMIT;
  - be is one of 0001/0010/0100/1000/0011/1100/1111;
  - be is consistent with addr[1:0] (halfword: addr[0]=0; word: addr[1:0]=0).
- ISSUE:
  - mem_en=1, mem_we=latched we, mem_addr={addr[31:2],2'b00}, mem_wdata, mem_be for exactly one cycle.
  - Then go to RESP. mem_en is 0 in every other state.
- RESP:
  - rsp_valid[owner]=1 for one cycle.
  - rsp_err=error flag.
  - rsp_rdata=mem_rdata for legal reads; 0 for writes and errors.
  - Then go to IDLE. req_ready is 0 in this cycle.
- Latency: accept at cycle T, mem_en at T+1, rsp_valid at T+2. An illegal request responds at T+1 and never asserts mem_en.
- Throughput: one accept per 3 cycles (2 for errors). No back-to-back accept in RESP.
- Starvation counter:
  - Increments on each port-0 grant made while req_valid[1]=1, saturating at STARVE_LIMIT.
  - Clears on any port-1 grant.
  - Unchanged when port 1 is not requesting.
- Requesters hold valid and payload stable until ready. The arbiter samples the payload only in the accept cycle, so later changes have no effect.
- Simultaneous requests with starve_cnt<STARVE_LIMIT: port 0 wins.

Decomposition:
- Package dmem_pkg holds:
  - state_t enum (IDLE, ISSUE, RESP);
  - BE_BYTE/BE_HALF/BE_WORD constants;
  - the function be_legal(addr, be).
- One sub-module, dmem_arb_prio: combinational grant logic plus the starve counter. The FSM and request latch stay in the top.

Test Plan:
- Single read, port 0: mem[0x100..0x103]=DE AD BE EF, req addr=0x100, be=1111. Expect mem_en at T+1 and rsp_valid[0] at T+2 with rdata=0xEFBEADDE, err=0.
- Byte write, port 1: addr=0x203, be=1000, wdata=0x5A000000. Expect mem_addr=0x200, mem_be=1000, mem_we=1 at T+1 and rsp_valid[1] at T+2. A subsequent read of 0x200 returns 0x5A in byte 3 only.
- Misaligned word: addr=0x102, be=1111. Expect rsp_valid at T+1 with err=1, no mem_en, memory unchanged. Same for addr=0x20000 (out of range).
- Contention/starvation, STARVE_LIMIT=4: both ports valid continuously. Grant order is 0,0,0,0,1,0,0,0,0,1, and each rsp_valid goes to the correct port.
- Reset mid-op: assert rst_n=0 in the ISSUE cycle of a write. Expect all outputs 0 immediately, no rsp_valid after release, and the addressed memory location unchanged.
- Payload change after accept: alter req_addr in ISSUE. Expect mem_addr to reflect the originally latched address.
